// File: rtl/decoder_mw_if.sv
// ---------------------------------------------------------------------------
// axis_if : AXI-Stream style valid/ready channel used on both sides of the
//           RV32 decoder (decoder_mw).
//
// Parameters:
//   W        payload width in bits
// Signals:
//   tvalid   producer has a beat on tdata
//   tready   consumer accepts the beat this cycle
//   tdata    payload
// Modports:
//   m        producer side (drives tvalid/tdata)
//   s        consumer side (drives tready)
// ---------------------------------------------------------------------------
interface axis_if #(
  parameter int W = 32
) ();
  logic         tvalid;
  logic         tready;
  logic [W-1:0] tdata;

  modport m (output tvalid, output tdata, input  tready);
  modport s (input  tvalid, input  tdata, output tready);
endinterface

// File: rtl/decoder_mw.sv
// ---------------------------------------------------------------------------
// decoder_mw : RV32I instruction decoder with illegal-instruction detection,
//              LSU command decode, a destination-register history for
//              forwarding hints, and a flushable output FIFO.
//
// Optional feature macro: DECODER_RV32M_EN (adds MUL/DIV decode, mdu_* fields)
//
// Parameters:
//   FIFO_DEPTH   output FIFO entries (>=2)
//   FWD_DEPTH    number of previous rd values tracked (1..8)
// Ports:
//   clk           clock
//   rst           asynchronous active-low reset
//   ifid_axis_if  slave stream, tdata = {pc[31:0], inst[31:0]}
//   idrf_axis_if  master stream, tdata = idrf_mw_tdata_t decoded packet
//   invalidate    one-cycle pipeline flush (empties FIFO, clears history)
//   level         current FIFO occupancy
// ---------------------------------------------------------------------------
module decoder_mw #(
  parameter int FIFO_DEPTH = 9,
  parameter int FWD_DEPTH  = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  axis_if.s                               ifid_axis_if,
  axis_if.m                               idrf_axis_if,
  input  logic                            invalidate,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] level
);

  localparam int LVL_W = $clog2(FIFO_DEPTH+1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  // BRU command reuses branch funct3; 010/011 are illegal for branches,
  // so they are free to encode JAL/JALR.
  localparam logic [2:0] BRU_JAL  = 3'b010;
  localparam logic [2:0] BRU_JALR = 3'b011;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ifid_tdata_t;

  // alu_cmd = {alt, funct3}: alt selects SUB (funct3 000) or SRA (funct3 101)
  typedef struct packed {
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [4:0]           rd;
    logic [31:0]          immediate;
    logic [31:0]          auipc;
    logic [FWD_DEPTH-1:0] fwd_rs1;
    logic [FWD_DEPTH-1:0] fwd_rs2;
    logic                 alu_cmd_vld;
    logic [3:0]           alu_cmd;
    logic                 bru_cmd_vld;
    logic [2:0]           bru_cmd;
    logic                 lsu_cmd_vld;
    logic                 lsu_store;
    logic [2:0]           lsu_funct3;
`ifdef DECODER_RV32M_EN
    logic                 mdu_cmd_vld;
    logic [2:0]           mdu_cmd;
`endif
    logic                 illegal;
    logic [63:0]          if_data;
  } idrf_mw_tdata_t;

  ifid_tdata_t    in_s;
  idrf_mw_tdata_t dec_s;   // decoded packet, forwarding vectors still zero
  idrf_mw_tdata_t push_s;  // packet written into the FIFO
  logic [6:0]     opcode;
  logic [2:0]     f3;
  logic [6:0]     f7;
  logic           use_rs1, use_rs2, use_rd;

  assign in_s   = ifid_axis_if.tdata;
  assign opcode = in_s.inst[6:0];
  assign f3     = in_s.inst[14:12];
  assign f7     = in_s.inst[31:25];

  // ---------------- combinational decode ----------------
  always_comb begin
    dec_s         = '0;
    dec_s.if_data = in_s;
    use_rs1       = 1'b0;
    use_rs2       = 1'b0;
    use_rd        = 1'b0;
    case (opcode)
      OPC_LUI: begin
        use_rd = 1'b1;
        dec_s.immediate   = {in_s.inst[31:12], 12'b0};
        dec_s.alu_cmd_vld = 1'b1;
      end
      OPC_AUIPC: begin
        use_rd = 1'b1;
        dec_s.immediate   = {in_s.inst[31:12], 12'b0};
        dec_s.auipc       = in_s.pc;
        dec_s.alu_cmd_vld = 1'b1;
      end
      OPC_JAL: begin
        use_rd = 1'b1;
        dec_s.immediate   = {{11{in_s.inst[31]}}, in_s.inst[31], in_s.inst[19:12],
                             in_s.inst[20], in_s.inst[30:21], 1'b0};
        dec_s.bru_cmd_vld = 1'b1;
        dec_s.bru_cmd     = BRU_JAL;
      end
      OPC_JALR: begin
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        dec_s.immediate   = {{20{in_s.inst[31]}}, in_s.inst[31:20]};
        dec_s.bru_cmd_vld = 1'b1;
        dec_s.bru_cmd     = BRU_JALR;
        dec_s.illegal     = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        dec_s.immediate   = {{19{in_s.inst[31]}}, in_s.inst[31], in_s.inst[7],
                             in_s.inst[30:25], in_s.inst[11:8], 1'b0};
        dec_s.bru_cmd_vld = 1'b1;
        dec_s.bru_cmd     = f3;
        dec_s.illegal     = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_LOAD: begin
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        dec_s.immediate   = {{20{in_s.inst[31]}}, in_s.inst[31:20]};
        dec_s.lsu_cmd_vld = 1'b1;
        dec_s.lsu_funct3  = f3;
        dec_s.illegal     = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        dec_s.immediate   = {{20{in_s.inst[31]}}, in_s.inst[31:25], in_s.inst[11:7]};
        dec_s.lsu_cmd_vld = 1'b1;
        dec_s.lsu_store   = 1'b1;
        dec_s.lsu_funct3  = f3;
        dec_s.illegal     = (f3 >= 3'b011);
      end
      OPC_OP_IMM: begin
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        dec_s.immediate   = {{20{in_s.inst[31]}}, in_s.inst[31:20]};
        dec_s.alu_cmd_vld = 1'b1;
        // inst[30] is part of the immediate except for the right shifts
        dec_s.alu_cmd     = {(f3 == 3'b101) && in_s.inst[30], f3};
        dec_s.illegal     = ((f3 == 3'b001) && (f7 != 7'b0000000)) ||
                            ((f3 == 3'b101) && (f7 != 7'b0000000) && (f7 != 7'b0100000));
      end
      OPC_OP: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
        if (f7 == 7'b0000000) begin
          dec_s.alu_cmd_vld = 1'b1;
          dec_s.alu_cmd     = {1'b0, f3};
        end else if ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))) begin
          dec_s.alu_cmd_vld = 1'b1;
          dec_s.alu_cmd     = {1'b1, f3};
`ifdef DECODER_RV32M_EN
        end else if (f7 == 7'b0000001) begin
          dec_s.mdu_cmd_vld = 1'b1;
          dec_s.mdu_cmd     = f3;
`endif
        end else begin
          dec_s.illegal = 1'b1;
        end
      end
      OPC_MISC_MEM: begin
        // FENCE: legal no-op, nothing to issue
      end
      default: dec_s.illegal = 1'b1;
    endcase

    if (in_s.inst[1:0] != 2'b11) dec_s.illegal = 1'b1;

    dec_s.rs1 = use_rs1 ? in_s.inst[19:15] : 5'd0;
    dec_s.rs2 = use_rs2 ? in_s.inst[24:20] : 5'd0;
    dec_s.rd  = use_rd  ? in_s.inst[11:7]  : 5'd0;

    // Illegal packets still travel to the back end, but must not issue
    // or pollute the forwarding history.
    if (dec_s.illegal) begin
      dec_s.alu_cmd_vld = 1'b0;
      dec_s.bru_cmd_vld = 1'b0;
      dec_s.lsu_cmd_vld = 1'b0;
`ifdef DECODER_RV32M_EN
      dec_s.mdu_cmd_vld = 1'b0;
`endif
      dec_s.rd          = 5'd0;
    end
  end

  // ---------------- forwarding history ----------------
  logic [4:0]           hist_rd_q  [FWD_DEPTH];
  logic                 hist_vld_q [FWD_DEPTH];
  logic [FWD_DEPTH-1:0] hit_rs1, hit_rs2;
  logic                 push, pop, full;

  generate
    for (genvar gi = 0; gi < FWD_DEPTH; gi++) begin : g_hist
      assign hit_rs1[gi] = hist_vld_q[gi] && (hist_rd_q[gi] == dec_s.rs1) && (dec_s.rs1 != 5'd0);
      assign hit_rs2[gi] = hist_vld_q[gi] && (hist_rd_q[gi] == dec_s.rs2) && (dec_s.rs2 != 5'd0);

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          hist_rd_q[gi]  <= 5'd0;
          hist_vld_q[gi] <= 1'b0;
        end else if (invalidate) begin
          hist_vld_q[gi] <= 1'b0;
        end else if (push) begin
          if (gi == 0) begin
            hist_rd_q[gi]  <= dec_s.rd;
            hist_vld_q[gi] <= (dec_s.rd != 5'd0);
          end else begin
            hist_rd_q[gi]  <= hist_rd_q[(gi > 0) ? gi-1 : 0];
            hist_vld_q[gi] <= hist_vld_q[(gi > 0) ? gi-1 : 0];
          end
        end
      end
    end
  endgenerate

  // x & -x isolates the lowest set bit: the youngest matching producer.
  always_comb begin
    push_s = dec_s;
    if (!dec_s.illegal) begin
      push_s.fwd_rs1 = hit_rs1 & (~hit_rs1 + 1'b1);
      push_s.fwd_rs2 = hit_rs2 & (~hit_rs2 + 1'b1);
    end
  end

  // ---------------- output FIFO ----------------
  idrf_mw_tdata_t   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] count_q, count_d;
  logic             rdy_q;  // low in reset, high from the first edge after release

  assign full                = (count_q == LVL_W'(FIFO_DEPTH));
  assign ifid_axis_if.tready = rdy_q && !full && !invalidate;
  assign push                = ifid_axis_if.tvalid && ifid_axis_if.tready;
  assign idrf_axis_if.tvalid = (count_q != '0);
  assign idrf_axis_if.tdata  = mem_q[rd_ptr_q];
  assign pop                 = idrf_axis_if.tvalid && idrf_axis_if.tready;
  assign level               = count_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdy_q    <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (invalidate) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
        count_q <= count_d;
      end
    end
  end

  // Storage carries no reset; occupancy alone defines what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_s;
  end

endmodule

// File: tb/tb_decoder_mw.sv
// ---------------------------------------------------------------------------
// tb_decoder_mw : directed self-checking bench for decoder_mw (default
//                 parameters FIFO_DEPTH=9, FWD_DEPTH=3).
// ---------------------------------------------------------------------------
module tb_decoder_mw;

  localparam int FIFO_DEPTH = 9;
  localparam int FWD_DEPTH  = 3;

  typedef struct packed {
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [4:0]           rd;
    logic [31:0]          immediate;
    logic [31:0]          auipc;
    logic [FWD_DEPTH-1:0] fwd_rs1;
    logic [FWD_DEPTH-1:0] fwd_rs2;
    logic                 alu_cmd_vld;
    logic [3:0]           alu_cmd;
    logic                 bru_cmd_vld;
    logic [2:0]           bru_cmd;
    logic                 lsu_cmd_vld;
    logic                 lsu_store;
    logic [2:0]           lsu_funct3;
`ifdef DECODER_RV32M_EN
    logic                 mdu_cmd_vld;
    logic [2:0]           mdu_cmd;
`endif
    logic                 illegal;
    logic [63:0]          if_data;
  } pkt_t;

  localparam int PKT_W = $bits(pkt_t);

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       invalidate = 1'b0;
  logic [3:0] level;
  int         errors = 0;
  int         checks = 0;

  axis_if #(.W(64))    ifid_if ();
  axis_if #(.W(PKT_W)) idrf_if ();

  decoder_mw #(.FIFO_DEPTH(FIFO_DEPTH), .FWD_DEPTH(FWD_DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .ifid_axis_if (ifid_if),
    .idrf_axis_if (idrf_if),
    .invalidate   (invalidate),
    .level        (level)
  );

  always #5 clk = ~clk;

  pkt_t out_pkt;
  assign out_pkt = pkt_t'(idrf_if.tdata);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one beat; valid stays high after the accepting edge so bursts are
  // back-to-back. Call idle() to release the bus.
  task automatic push(input logic [31:0] pc, input logic [31:0] inst);
    int n = 0;
    @(negedge clk);
    ifid_if.tvalid = 1'b1;
    ifid_if.tdata  = {pc, inst};
    while (!ifid_if.tready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("push_timeout", 64'd0, 64'd1);
    @(posedge clk);
    $display("push pc=%08h inst=%08h", pc, inst);
  endtask

  task automatic idle();
    @(negedge clk);
    ifid_if.tvalid = 1'b0;
  endtask

  task automatic pop(output pkt_t p);
    int n = 0;
    @(negedge clk);
    while (!idrf_if.tvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("pop_timeout", 64'd0, 64'd1);
    p = out_pkt;
    idrf_if.tready = 1'b1;
    @(posedge clk);
    #1 idrf_if.tready = 1'b0;
    $display("pop  inst=%08h illegal=%0d rd=%0d imm=%08h", p.if_data[31:0], p.illegal, p.rd, p.immediate);
  endtask

  task automatic push_pop(input logic [31:0] pc, input logic [31:0] inst, output pkt_t p);
    push(pc, inst);
    idle();
    pop(p);
  endtask

  pkt_t p, saved;

  initial begin
    ifid_if.tvalid = 1'b0;
    ifid_if.tdata  = '0;
    idrf_if.tready = 1'b0;

    // ---- reset ----
    #3;
    check("rst_in_ready", 64'(ifid_if.tready), 64'd0);
    check("rst_out_valid", 64'(idrf_if.tvalid), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1 check("release_ready_low", 64'(ifid_if.tready), 64'd0);
    @(negedge clk);
    check("release_ready_high", 64'(ifid_if.tready), 64'd1);

    // ---- ADDI x1,x0,5 ----
    push(32'h100, 32'h00500093);
    idle();
    check("addi_level", 64'(level), 64'd1);
    check("addi_valid", 64'(idrf_if.tvalid), 64'd1);
    check("addi_rd", 64'(out_pkt.rd), 64'd1);
    check("addi_imm", 64'(out_pkt.immediate), 64'd5);
    check("addi_alu_vld", 64'(out_pkt.alu_cmd_vld), 64'd1);
    check("addi_alu_cmd", 64'(out_pkt.alu_cmd), 64'd0);
    check("addi_fwd1", 64'(out_pkt.fwd_rs1), 64'd0);
    check("addi_illegal", 64'(out_pkt.illegal), 64'd0);
    pop(p);

    // ---- back-to-back forwarding ----
    push(32'h104, 32'h00500093);   // ADDI x1,x0,5
    push(32'h108, 32'h00700113);   // ADDI x2,x0,7
    push(32'h10C, 32'h002081B3);   // ADD x3,x1,x2
    idle();
    check("b2b_level", 64'(level), 64'd3);
    pop(p);
    check("b2b0_rd", 64'(p.rd), 64'd1);
    pop(p);
    check("b2b1_imm", 64'(p.immediate), 64'd7);
    check("b2b1_fwd1", 64'(p.fwd_rs1), 64'd0);
    pop(p);
    check("add_rd", 64'(p.rd), 64'd3);
    check("add_fwd1", 64'(p.fwd_rs1), 64'b010);
    check("add_fwd2", 64'(p.fwd_rs2), 64'b001);

    // ---- illegal encodings ----
    push(32'h110, 32'h00000000);
    push(32'h114, 32'hFFFFFFFF);
    push(32'h118, 32'h000002B3);   // ADD x5,x0,x0
    idle();
    for (int i = 0; i < 2; i++) begin
      pop(p);
      check("ill_flag", 64'(p.illegal), 64'd1);
      check("ill_vld", 64'({p.alu_cmd_vld, p.bru_cmd_vld, p.lsu_cmd_vld}), 64'd0);
      check("ill_rd", 64'(p.rd), 64'd0);
    end
    pop(p);
    check("add5_illegal", 64'(p.illegal), 64'd0);
    check("add5_rd", 64'(p.rd), 64'd5);
    check("add5_fwd", 64'({p.fwd_rs1, p.fwd_rs2}), 64'd0);

    // ---- assorted formats ----
    push_pop(32'h200, 32'h0040A483, p);   // LW x9,4(x1)
    check("lw_lsu", 64'({p.lsu_cmd_vld, p.lsu_store, p.lsu_funct3}), 64'b1_0_010);
    check("lw_rd_imm", 64'({p.rd, p.immediate}), {27'd0, 5'd9, 32'd4});
    push_pop(32'h204, 32'hFE20AE23, p);   // SW x2,-4(x1)
    check("sw_lsu", 64'({p.lsu_cmd_vld, p.lsu_store, p.lsu_funct3}), 64'b1_1_010);
    check("sw_imm", 64'(p.immediate), 64'hFFFFFFFC);
    check("sw_rd", 64'(p.rd), 64'd0);
    push_pop(32'h208, 32'h12345517, p);   // AUIPC x10,0x12345
    check("auipc_val", 64'(p.auipc), 64'h208);
    check("auipc_imm", 64'(p.immediate), 64'h12345000);
    push_pop(32'h20C, 32'h40345413, p);   // SRAI x8,x8,3
    check("srai_cmd", 64'(p.alu_cmd), 64'd13);
    push_pop(32'h210, 32'h401183B3, p);   // SUB x7,x3,x1
    check("sub_cmd", 64'(p.alu_cmd), 64'd8);
    push_pop(32'h214, 32'h00002063, p);   // branch funct3=010
    check("br010_illegal", 64'(p.illegal), 64'd1);
    check("br010_bru", 64'(p.bru_cmd_vld), 64'd0);
    push_pop(32'h218, 32'h02208333, p);   // MUL x6,x1,x2
`ifdef DECODER_RV32M_EN
    check("mul_illegal", 64'(p.illegal), 64'd0);
    check("mul_mdu", 64'({p.mdu_cmd_vld, p.mdu_cmd}), 64'b1_000);
    check("mul_alu", 64'(p.alu_cmd_vld), 64'd0);
    check("mul_rd", 64'(p.rd), 64'd6);
`else
    check("mul_illegal", 64'(p.illegal), 64'd1);
    check("mul_rd", 64'(p.rd), 64'd0);
`endif

    // ---- fill FIFO, stall, push+pop at full, drain ----
    for (int i = 1; i <= 9; i++)
      push(32'h300 + 32'(i), (32'(i) << 20) | (32'(i) << 7) | 32'h13);
    idle();
    check("full_level", 64'(level), 64'd9);
    check("full_ready", 64'(ifid_if.tready), 64'd0);
    saved = out_pkt;
    repeat (2) @(negedge clk);
    check("stall_stable", 64'(out_pkt == saved), 64'd1);
    check("stall_head_imm", 64'(out_pkt.immediate), 64'd1);
    // simultaneous push and pop while full
    ifid_if.tvalid = 1'b1;
    ifid_if.tdata  = {32'h30A, 32'h00A00513};   // ADDI x10,x0,10
    idrf_if.tready = 1'b1;
    #1 check("fullpp_ready", 64'(ifid_if.tready), 64'd0);
    @(negedge clk);
    idrf_if.tready = 1'b0;
    check("fullpp_level", 64'(level), 64'd8);
    check("fullpp_ready2", 64'(ifid_if.tready), 64'd1);
    @(negedge clk);
    ifid_if.tvalid = 1'b0;
    check("fullpp_refill", 64'(level), 64'd9);
    for (int i = 2; i <= 10; i++) begin
      pop(p);
      check("drain_imm", 64'(p.immediate), 64'(i));
      check("drain_rd", 64'(p.rd), 64'(i));
    end
    check("drain_empty", 64'(idrf_if.tvalid), 64'd0);

    // ---- invalidate ----
    for (int i = 0; i < 4; i++) push(32'h400 + 32'(4*i), 32'h00500093);
    idle();
    check("inv_pre_level", 64'(level), 64'd4);
    @(negedge clk);
    invalidate = 1'b1;
    #1 check("inv_ready", 64'(ifid_if.tready), 64'd0);
    @(negedge clk);
    invalidate = 1'b0;
    check("inv_level", 64'(level), 64'd0);
    check("inv_valid", 64'(idrf_if.tvalid), 64'd0);
    push_pop(32'h410, 32'h00108233, p);   // ADD x4,x1,x1
    check("inv_add_rd", 64'(p.rd), 64'd4);
    check("inv_add_fwd", 64'({p.fwd_rs1, p.fwd_rs2}), 64'd0);

    // ---- reset mid-stream ----
    push(32'h500, 32'h00500093);
    push(32'h504, 32'h00700113);
    idle();
    #2 rst = 1'b0;
    #1;
    check("mrst_level", 64'(level), 64'd0);
    check("mrst_valid", 64'(idrf_if.tvalid), 64'd0);
    check("mrst_ready", 64'(ifid_if.tready), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_ready_back", 64'(ifid_if.tready), 64'd1);
    check("mrst_level_after", 64'(level), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop so a wedged design still produces a report.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/decoder_mw.md
Name: decoder_mw

Overview:
- Next-generation RV32 instruction decoder between the IFU (ifid_axis_if) and the register file (idrf_axis_if).
- Adds illegal-instruction detection, LSU command decode and a configurable-depth destination-register history for multi-stage forwarding hints.
- Output is buffered in a parametrised flushable AXIS FIFO so the IFU can run ahead of the back end.

Parameters:
- FIFO_DEPTH, 9, output FIFO entries (>=2)
- FWD_DEPTH, 3, number of previously decoded rd values tracked for forwarding (1..8)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- ifid_axis_if  axis_if.s  $bits(ifid_tdata_t)  fetched {pc, inst} from IFU
- idrf_axis_if  axis_if.m  $bits(idrf_mw_tdata_t)  decoded packet to register file
- invalidate  in  1  pipeline flush (branch mispredict / trap)
- level  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy

Behaviour:
- Packet idrf_mw_tdata_t fields:
  - rs1, rs2, rd, immediate[31:0], auipc[31:0]
  - fwd_rs1[FWD_DEPTH-1:0], fwd_rs2[FWD_DEPTH-1:0]
  - alu_cmd_vld, alu_cmd, bru_cmd_vld, bru_cmd
  - lsu_cmd_vld, lsu_store, lsu_funct3
  - illegal, if_data
- Field extraction and immediates per RV32I R/I/S/B/U/J formats; sign-extended to 32 bits.
- auipc = pc for AUIPC, else 0.
- Unused rs/rd fields are forced to 0.
- ALU decode:
  - funct3 000: SUB only when opcode==OP and inst[30]; otherwise ADD.
  - funct3 101: SRA when inst[30], else SRL.
- Illegal (illegal=1) when any of the following holds:
  - inst[1:0]!=2'b11
  - opcode not in {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, MISC_MEM}
  - BRANCH funct3 in {010, 011}
  - LOAD funct3 in {011, 110, 111}
  - STORE funct3 >= 011
  - JALR funct3 != 000
  - OP funct7 not 0000000, or 0100000 with funct3 not in {000, 101}
  - OP_IMM shift with a funct7 other than 0000000/0100000 (0100000 only valid for funct3 101)
- On illegal: all *_cmd_vld=0, rd=0, fwd vectors=0; the packet is still forwarded so the back end can trap.
- MISC_MEM (FENCE) decodes as a legal no-op: all cmd_vld=0, rd=0.
- Forwarding history:
  - Shift register hist_rd[FWD_DEPTH] plus hist_vld[FWD_DEPTH]; index 0 is youngest.
  - On each input handshake, shifts in {rd, rd!=0}.
  - fwd_rsX[k]=1 only for the smallest k with hist_vld[k] && hist_rd[k]==rsX && rsX!=0 (one-hot or zero).
  - Computed from history state before the current packet is shifted in.
- Handshake:
  - ifid tready = FIFO not full && !invalidate.
  - Accept iff tvalid && tready.
  - Decode is combinational into the FIFO; earliest idrf tvalid is 1 cycle after accept.
  - Full throughput: 1 packet/cycle while not full.
  - Output tdata holds stable while tvalid && !tready.
- FIFO full: tready=0; history unchanged.
- FIFO empty: idrf tvalid=0.
- Simultaneous push and pop when full: the pop frees the slot next cycle; tready stays 0 in the current cycle.
- invalidate (synchronous, 1 cycle):
  - Empties the FIFO and clears hist_vld.
  - level=0 next cycle; no input accepted that cycle.
  - A pop in the same cycle is allowed and completes.
- Reset (async assert, sync release): idrf tvalid=0, ifid tready=0 while asserted, level=0, hist_vld=0.
  - Reset mid-stream discards all buffered packets.
  - tready rises the first cycle after release.

Optional Feature:
- Macro DECODER_RV32M_EN.
- Defined: OP with funct7=0000001 is legal and sets mdu_cmd_vld=1, mdu_cmd=funct3 (MUL..REMU), alu_cmd_vld=0, rd tracked in history normally.
- Undefined: field mdu_cmd_vld absent; funct7=0000001 is illegal.

Test Plan:
- Reset, push ADDI x1,x0,5 (0x00500093) -> 1 cycle later: rd=1, immediate=5, alu_cmd=ADD, fwd_rs1=0, illegal=0; level=1.
- Back-to-back: ADDI x1; ADDI x2; ADD x3,x1,x2 (FWD_DEPTH=3) -> ADD packet fwd_rs1=3'b010, fwd_rs2=3'b001.
- Push 0x00000000 and 0xFFFFFFFF -> both delivered with illegal=1, cmd_vld=0, rd=0; a following ADD x5,x0,x0 reports fwd vectors 0.
- Hold idrf tready=0, push 9 packets (FIFO_DEPTH=9) -> level=9, ifid tready=0; drain order/data unchanged and stable while stalled.
- With 4 packets buffered, assert invalidate one cycle -> level=0 next cycle, idrf tvalid=0; next ADD x4,x1,x1 gets fwd_rs1=0.
- With DECODER_RV32M_EN: MUL x6,x1,x2 (0x02208333) -> mdu_cmd_vld=1, mdu_cmd=0, illegal=0; without the macro: illegal=1.
